// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv shared definitions: M-extension funct3 codes and decode helpers.
// Imported by the iterative multiply/divide unit and its bench.
package alu_muldiv_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   function automatic logic md_is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic md_is_rem(input logic [2:0] f);
      return f[2] & f[1];
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide.
// acc ends as {hi,lo} product, or {remainder,quotient}.
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              mode_div,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic [2*XLEN-1:0] acc
);

   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] acc_nx;

   always_comb begin
      addend  = acc[0] ? b_q : {XLEN{1'b0}};
      add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
      rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = rem_sh - {1'b0, b_q};
      acc_nx  = {add_sum, acc[XLEN-1:1]};
      if (mode_div) begin
         // borrow in the top bit means the trial subtract is restored
         if (!diff[XLEN])
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         b_q <= '0;
      end else if (load) begin
         acc <= {{XLEN{1'b0}}, a_mag};
         b_q <= b_mag;
      end else if (step) begin
         acc <= acc_nx;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension unit: fixed XLEN+1 cycle latency,
// sign handling around an unsigned engine, flushable.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int CNTW = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct_md,
   input  logic [XLEN-1:0] mdin1,
   input  logic [XLEN-1:0] mdin2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] mdout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [CNTW-1:0]   cnt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              dz_q;
   logic [XLEN-1:0]   a_raw_q;
   logic [XLEN-1:0]   mdout_q;

   logic              a_signed, b_signed;
   logic              a_sgn, b_sgn;
   logic              neg_nx;
   logic              accept;
   logic              last_step;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN-1:0]   quo, rem, result;
   logic [2*XLEN-1:0] acc, prod;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct_md)
         MD_MULH, MD_DIV, MD_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         MD_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_sgn  = a_signed & mdin1[XLEN-1];
      b_sgn  = b_signed & mdin2[XLEN-1];
      a_mag  = a_sgn ? -mdin1 : mdin1;
      b_mag  = b_sgn ? -mdin2 : mdin2;
      // remainder takes the dividend sign
      neg_nx = md_is_rem(funct_md) ? a_sgn : (a_sgn ^ b_sgn);
   end

   assign accept    = (state == S_IDLE) & start & ~flush;
   assign last_step = (cnt == CNTW'(1));

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (accept) state_nx = S_CALC;
         S_CALC: begin
            if (flush)          state_nx = S_IDLE;
            else if (last_step) state_nx = S_DONE;
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE) & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
         a_raw_q <= '0;
         mdout_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt     <= CNTW'(XLEN);
            op_q    <= funct_md;
            neg_q   <= neg_nx;
            dz_q    <= (mdin2 == '0);
            a_raw_q <= mdin1;
         end else if (state == S_CALC) begin
            cnt <= cnt - CNTW'(1);
         end
         if (done) mdout_q <= result;
      end
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (state == S_CALC),
      .mode_div (md_is_div(op_q)),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .acc      (acc)
   );

   always_comb begin
      prod   = neg_q ? -acc : acc;
      quo    = acc[XLEN-1:0];
      rem    = acc[2*XLEN-1:XLEN];
      result = acc[XLEN-1:0];
      case (op_q)
         MD_MUL: result = acc[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:
            result = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:
            result = dz_q ? {XLEN{1'b1}} : (neg_q ? -quo : quo);
         default:
            result = dz_q ? a_raw_q : (neg_q ? -rem : rem);
      endcase
   end

   // result is live during DONE so mdout is valid with the done pulse
   assign mdout = done ? result : mdout_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (XLEN=32): results and latency
// are queued at issue and checked on each done pulse.
module tb_alu_muldiv;
   import alu_muldiv_pkg::*;

   localparam int LAT = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct_md;
   logic [31:0] mdin1, mdin2;
   logic        flush;
   logic        busy, done;
   logic [31:0] mdout;

   typedef struct {
      string       tag;
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] last_exp = '0;
   int          t0;

   alu_muldiv #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct_md (funct_md),
      .mdin1    (mdin1),
      .mdin2    (mdin2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .mdout    (mdout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      logic [63:0] ua, ub, p;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         MD_MUL:    begin p = ua * ub; return p[31:0]; end
         MD_MULH:   begin p = sa * sb2; return p[63:32]; end
         MD_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
         MD_MULHU:  begin p = ua * ub; return p[63:32]; end
         MD_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return $signed(a) / $signed(b);
         end
         MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         MD_REM: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", {31'b0, done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_res"}, mdout, e.res);
            chk({e.tag, "_lat"}, cyc, e.cyc);
            last_exp = e.res;
         end
      end
   end

   // caller sits just after a rising edge; returns one cycle after start
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input bit track, input string tag);
      int guard = 0;
      while (busy && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (busy) chk("issue_wait", {31'b0, busy}, 32'd0);
      funct_md = op;
      mdin1    = a;
      mdin2    = b;
      start    = 1'b1;
      if (track) sb.push_back('{tag: tag, res: res, cyc: cyc + LAT});
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || busy) && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() != 0) chk("drain", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      funct_md = '0;
      mdin1    = '0;
      mdin2    = '0;
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_mdout", mdout, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, "mul");
      issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 1, "mulhu");
      issue(MD_MULH, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 1, "mulh");
      issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 1, "mulhsu");
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, "div");
      issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, "rem");
      issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 1, "divu");
      issue(MD_REMU, 32'd100, 32'd7, 32'd2, 1, "remu");
      issue(MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
      issue(MD_REMU, 32'd5, 32'd0, 32'd5, 1, "remu0");
      issue(MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem0");
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 1, "div_ovf");
      issue(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
      drain();

      // start while busy must be ignored
      issue(MD_MUL, 32'd1234, 32'd5678, 32'd7006652, 1, "mul_busy");
      repeat (5) begin @(posedge clk); #1; end
      funct_md = MD_DIVU;
      mdin1    = 32'd99;
      mdin2    = 32'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drain();

      // flush together with start in IDLE
      funct_md = MD_MUL;
      start    = 1'b1;
      flush    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      chk("flush_start_busy", {31'b0, busy}, 32'd0);

      // flush at T+10, restart at T+11
      issue(MD_DIVU, 32'd1000, 32'd3, 32'd0, 0, "flushed");
      t0 = cyc - 1;
      while (cyc < t0 + 10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_mdout", mdout, last_exp);
      chk("flush_cyc", cyc, t0 + 11);
      issue(MD_DIVU, 32'd1000, 32'd3, 32'd333, 1, "post_flush");
      drain();

      // async reset between edges mid-CALC
      issue(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 0, "rst_op");
      repeat (8) begin @(posedge clk); #1; end
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_mdout", mdout, 32'd0);
      last_exp = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, "post_rst");

      for (int i = 0; i < 16; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 5 == 0) ? 32'd0 : $urandom;
         if (i % 4 == 1) b = 32'($urandom_range(1, 20));
         issue(op, a, b, ref_md(op, a, b), 1, "rnd");
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
